// File: rtl/pe_stream_dist.sv
// pe_stream_dist: steers a 64-bit packetised word stream onto the two PE
// input ports (Q / Q2), or drops it, as selected by each packet's header word.
//
// Ports:
//   CLK, SYS_RST_N      clock (rising edge), asynchronous active-low reset
//   IN, IN_VALID        input word stream; the source has no ready signal
//   IN_BP               almost-full backpressure to the source
//   Q, Q_VALID, Q_BP    PE input 1 data, valid, and almost-full
//   Q2, Q2_VALID, Q2_BP PE input 2 data, valid, and almost-full
//   PKT_DONE            one-cycle pulse per completed packet
//   PKT_CNT             completed-packet counter (wraps)
//   OVF                 sticky flag: an input word was lost to a full buffer
//
// Header word: [63:62] mode (00 Q, 01 Q2, 10 interleave, 11 drop),
//              [31:0] payload word count N.
//
// state | meaning
// ------+-------------------------------------------------------------
// HDR   | waiting for a header word; pops it and loads mode / count
// PAY   | forwarding payload words to Q / Q2, honouring the port's BP
// DROP  | discarding payload words, one per cycle while data is buffered

module pe_stream_dist #(
   parameter int DEPTH     = 16,
   parameter int BP_MARGIN = 4
) (
   input  logic        CLK,
   input  logic        SYS_RST_N,
   input  logic [63:0] IN,
   input  logic        IN_VALID,
   output logic        IN_BP,
   output logic [63:0] Q,
   output logic        Q_VALID,
   input  logic        Q_BP,
   output logic [63:0] Q2,
   output logic        Q2_VALID,
   input  logic        Q2_BP,
   output logic        PKT_DONE,
   output logic [31:0] PKT_CNT,
   output logic        OVF
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
   localparam logic [CW-1:0] C_BP_THR = CW'(DEPTH - BP_MARGIN);

   typedef enum logic [1:0] {
      S_HDR  = 2'd0,
      S_PAY  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [63:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic [1:0]    r_mode;
   logic [31:0]   r_rem;
   logic          r_idx;

   logic [63:0]   r_q;
   logic [63:0]   r_q2;
   logic          r_q_valid;
   logic          r_q2_valid;
   logic          r_pkt_done;
   logic [31:0]   r_pkt_cnt;
   logic          r_ovf;

   logic          w_empty;
   logic          w_wr;
   logic          w_pop;
   logic          w_hdr_load;
   logic          w_to_q;
   logic          w_to_q2;
   logic          w_done;
   logic          w_sel_q2;
   logic [63:0]   w_head;
   logic [1:0]    w_hdr_mode;
   logic [31:0]   w_hdr_n;

   assign w_empty    = (r_count == '0);
   assign w_head     = r_mem[r_rd_ptr];
   assign w_hdr_mode = w_head[63:62];
   assign w_hdr_n    = w_head[31:0];

   // Only the low index bit matters: it picks the interleave target.
   assign w_sel_q2 = (r_mode == 2'b01) || ((r_mode == 2'b10) && r_idx);

   // A full buffer still accepts a word when the head leaves on the same edge.
   assign w_wr = IN_VALID && ((r_count != C_DEPTH) || w_pop);

   always_ff @(posedge CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) r_state <= S_HDR;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_hdr_load  = 1'b0;
      w_to_q      = 1'b0;
      w_to_q2     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_HDR: begin
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_hdr_load = 1'b1;
               if (w_hdr_n == 32'd0)          w_done      = 1'b1;
               else if (w_hdr_mode == 2'b11) w_state_nxt = S_DROP;
               else                          w_state_nxt = S_PAY;
            end
         end
         S_PAY: begin
            if (!w_empty && !(w_sel_q2 ? Q2_BP : Q_BP)) begin
               w_pop   = 1'b1;
               w_to_q  = !w_sel_q2;
               w_to_q2 = w_sel_q2;
               if (r_rem == 32'd1) begin
                  w_done      = 1'b1;
                  w_state_nxt = S_HDR;
               end
            end
         end
         S_DROP: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (r_rem == 32'd1) begin
                  w_done      = 1'b1;
                  w_state_nxt = S_HDR;
               end
            end
         end
         default: w_state_nxt = S_HDR;
      endcase
   end

   // Storage array carries no reset; the count and pointers define its contents.
   always_ff @(posedge CLK) begin
      if (w_wr) r_mem[r_wr_ptr] <= IN;
   end

   always_ff @(posedge CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (IN_VALID && !w_wr) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         r_mode <= 2'b00;
         r_rem  <= '0;
         r_idx  <= 1'b0;
      end else if (w_hdr_load) begin
         r_mode <= w_hdr_mode;
         r_rem  <= w_hdr_n;
         r_idx  <= 1'b0;
      end else if (w_pop) begin
         r_rem  <= r_rem - 32'd1;
         r_idx  <= ~r_idx;
      end
   end

   always_ff @(posedge CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         r_q        <= '0;
         r_q2       <= '0;
         r_q_valid  <= 1'b0;
         r_q2_valid <= 1'b0;
         r_pkt_done <= 1'b0;
         r_pkt_cnt  <= '0;
      end else begin
         r_q_valid  <= w_to_q;
         r_q2_valid <= w_to_q2;
         r_pkt_done <= w_done;
         if (w_to_q)  r_q  <= w_head;
         if (w_to_q2) r_q2 <= w_head;
         if (w_done)  r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
   end

   assign IN_BP    = (r_count >= C_BP_THR);
   assign Q        = r_q;
   assign Q_VALID  = r_q_valid;
   assign Q2       = r_q2;
   assign Q2_VALID = r_q2_valid;
   assign PKT_DONE = r_pkt_done;
   assign PKT_CNT  = r_pkt_cnt;
   assign OVF      = r_ovf;

endmodule

// File: tb/tb_pe_stream_dist.sv
// Testbench for pe_stream_dist: directed scenarios plus a randomized packet
// stream, checked against per-port expected word queues built from headers.

module tb_pe_stream_dist;

   logic        CLK = 1'b0;
   logic        SYS_RST_N = 1'b0;
   logic [63:0] IN = '0;
   logic        IN_VALID = 1'b0;
   logic        IN_BP;
   logic [63:0] Q;
   logic        Q_VALID;
   logic        Q_BP = 1'b0;
   logic [63:0] Q2;
   logic        Q2_VALID;
   logic        Q2_BP = 1'b0;
   logic        PKT_DONE;
   logic [31:0] PKT_CNT;
   logic        OVF;

   pe_stream_dist #(.DEPTH(16), .BP_MARGIN(4)) dut (
      .CLK(CLK), .SYS_RST_N(SYS_RST_N),
      .IN(IN), .IN_VALID(IN_VALID), .IN_BP(IN_BP),
      .Q(Q), .Q_VALID(Q_VALID), .Q_BP(Q_BP),
      .Q2(Q2), .Q2_VALID(Q2_VALID), .Q2_BP(Q2_BP),
      .PKT_DONE(PKT_DONE), .PKT_CNT(PKT_CNT), .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_q2[$];
   int          exp_done = 0;
   int          seen_done = 0;
   logic [31:0] exp_cnt = '0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference: what a whole packet should produce on each port.
   task automatic expect_pkt(input logic [63:0] hdr, input logic [63:0] pl[$]);
      logic [1:0] mode;
      mode = hdr[63:62];
      for (int i = 0; i < pl.size(); i++) begin
         case (mode)
            2'b00: exp_q.push_back(pl[i]);
            2'b01: exp_q2.push_back(pl[i]);
            2'b10: if (i % 2 == 0) exp_q.push_back(pl[i]); else exp_q2.push_back(pl[i]);
            default: ;
         endcase
      end
      exp_done++;
      exp_cnt = exp_cnt + 32'd1;
   endtask

   task automatic observe(input logic qbp, input logic q2bp);
      if (qbp)  chk("q_sent_under_bp", {63'b0, Q_VALID}, 64'd0);
      if (q2bp) chk("q2_sent_under_bp", {63'b0, Q2_VALID}, 64'd0);
      if (exp_q.size() == 0)      chk("q_unexpected", {63'b0, Q_VALID}, 64'd0);
      else if (Q_VALID)           chk("q_data", Q, exp_q.pop_front());
      if (exp_q2.size() == 0)     chk("q2_unexpected", {63'b0, Q2_VALID}, 64'd0);
      else if (Q2_VALID)          chk("q2_data", Q2, exp_q2.pop_front());
      if (PKT_DONE) seen_done++;
   endtask

   // Called at a negedge: drive, let one rising edge pass, observe at next negedge.
   task automatic tick(input logic v, input logic [63:0] w, input logic qbp, input logic q2bp);
      IN_VALID = v;
      IN       = w;
      Q_BP     = qbp;
      Q2_BP    = q2bp;
      @(posedge CLK);
      @(negedge CLK);
      observe(qbp, q2bp);
   endtask

   task automatic idle(input int n, input logic qbp, input logic q2bp);
      for (int i = 0; i < n; i++) tick(1'b0, 64'd0, qbp, q2bp);
   endtask

   task automatic send_pkt(input logic [63:0] hdr, input logic [63:0] pl[$],
                           input logic qbp, input logic q2bp);
      expect_pkt(hdr, pl);
      tick(1'b1, hdr, qbp, q2bp);
      for (int i = 0; i < pl.size(); i++) tick(1'b1, pl[i], qbp, q2bp);
   endtask

   function automatic logic [63:0] mk_hdr(input logic [1:0] mode, input logic [31:0] n);
      return {mode, 30'h2AB5_0F0F, n};
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      logic [63:0] pl[$];
      logic [63:0] words[$];
      logic [63:0] w;
      int          base;
      int          cnt;

      // reset state
      #2;
      chk("rst_q", Q, 64'd0);
      chk("rst_q_valid", {63'b0, Q_VALID}, 64'd0);
      chk("rst_q2_valid", {63'b0, Q2_VALID}, 64'd0);
      chk("rst_pkt_cnt", {32'b0, PKT_CNT}, 64'd0);
      chk("rst_ovf", {63'b0, OVF}, 64'd0);
      chk("rst_in_bp", {63'b0, IN_BP}, 64'd0);
      @(negedge CLK);
      @(negedge CLK);
      SYS_RST_N = 1'b1;
      @(negedge CLK);

      // mode 00 with a 5-cycle Q_BP window mid-packet
      pl = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 64'hCCCC_0000_0000_000C};
      expect_pkt(mk_hdr(2'b00, 32'd3), pl);
      tick(1'b1, mk_hdr(2'b00, 32'd3), 1'b0, 1'b0);
      tick(1'b1, pl[0], 1'b0, 1'b0);
      tick(1'b1, pl[1], 1'b0, 1'b0);
      chk("m00_latency_a", {63'b0, Q_VALID}, 64'd1);
      tick(1'b1, pl[2], 1'b1, 1'b0);
      idle(4, 1'b1, 1'b0);
      chk("m00_held_words", exp_q.size(), 64'd2);
      idle(4, 1'b0, 1'b0);
      chk("m00_q_left", exp_q.size(), 64'd0);
      chk("m00_done", seen_done, exp_done);
      chk("m00_pkt_cnt", {32'b0, PKT_CNT}, {32'b0, exp_cnt});

      // interleave, Q2 blocked so word 3 must wait behind word 2
      pl = '{64'd1, 64'd2, 64'd3, 64'd4};
      send_pkt(mk_hdr(2'b10, 32'd4), pl, 1'b0, 1'b1);
      idle(4, 1'b0, 1'b1);
      chk("il_q_stalled", exp_q.size(), 64'd1);
      chk("il_q2_stalled", exp_q2.size(), 64'd2);
      idle(6, 1'b0, 1'b0);
      chk("il_q_left", exp_q.size(), 64'd0);
      chk("il_q2_left", exp_q2.size(), 64'd0);
      chk("il_done", seen_done, exp_done);

      // N=0, drop, then a single-word Q2 packet
      pl = '{};
      send_pkt(mk_hdr(2'b00, 32'd0), pl, 1'b0, 1'b0);
      pl = '{64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0002};
      send_pkt(mk_hdr(2'b11, 32'd2), pl, 1'b0, 1'b0);
      pl = '{64'h5A5A_1234_5678_9ABC};
      send_pkt(mk_hdr(2'b01, 32'd1), pl, 1'b0, 1'b0);
      idle(5, 1'b0, 1'b0);
      chk("nd_q2_left", exp_q2.size(), 64'd0);
      chk("nd_done", seen_done, exp_done);
      chk("nd_pkt_cnt", {32'b0, PKT_CNT}, {32'b0, exp_cnt});

      // randomized packets; source obeys IN_BP at once
      words = '{};
      for (int p = 0; p < 40; p++) begin
         logic [1:0]  mode;
         logic [31:0] n;
         mode = 2'($urandom_range(0, 3));
         n    = 32'($urandom_range(0, 6));
         pl   = '{};
         for (int i = 0; i < int'(n); i++) pl.push_back(rnd64());
         expect_pkt({mode, 30'($urandom), n}, pl);
         words.push_back({mode, 30'($urandom), n});
         words[words.size()-1][31:0] = n;
         foreach (pl[i]) words.push_back(pl[i]);
      end
      cnt = 0;
      while (words.size() > 0 && cnt < 5000) begin
         logic v;
         v = !IN_BP && ($urandom_range(0, 3) != 0);
         w = v ? words.pop_front() : 64'd0;
         tick(v, w, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
         cnt++;
      end
      chk("rand_all_sent", words.size(), 64'd0);
      cnt = 0;
      while (!(exp_q.size() == 0 && exp_q2.size() == 0 && seen_done == exp_done) && cnt < 1000) begin
         tick(1'b0, 64'd0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
         cnt++;
      end
      chk("rand_q_left", exp_q.size(), 64'd0);
      chk("rand_q2_left", exp_q2.size(), 64'd0);
      chk("rand_done", seen_done, exp_done);
      chk("rand_pkt_cnt", {32'b0, PKT_CNT}, {32'b0, exp_cnt});
      chk("rand_ovf", {63'b0, OVF}, 64'd0);

      // overflow: both ports blocked, 20 back-to-back words after a long header
      tick(1'b1, mk_hdr(2'b00, 32'd30), 1'b1, 1'b1);
      idle(1, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         w = rnd64();
         if (i < 16) exp_q.push_back(w);
         tick(1'b1, w, 1'b1, 1'b1);
         cnt = (i + 1 > 16) ? 16 : i + 1;
         chk("ovf_in_bp", {63'b0, IN_BP}, {63'b0, cnt >= 12});
         chk("ovf_flag", {63'b0, OVF}, {63'b0, i + 1 > 16});
      end
      idle(20, 1'b0, 1'b0);
      chk("ovf_stored_words", exp_q.size(), 64'd0);
      chk("ovf_sticky", {63'b0, OVF}, 64'd1);

      // reset mid-packet, asserted between edges
      #2;
      SYS_RST_N = 1'b0;
      #1;
      chk("mrst_q", Q, 64'd0);
      chk("mrst_q2", Q2, 64'd0);
      chk("mrst_q_valid", {63'b0, Q_VALID}, 64'd0);
      chk("mrst_q2_valid", {63'b0, Q2_VALID}, 64'd0);
      chk("mrst_pkt_done", {63'b0, PKT_DONE}, 64'd0);
      chk("mrst_pkt_cnt", {32'b0, PKT_CNT}, 64'd0);
      chk("mrst_ovf", {63'b0, OVF}, 64'd0);
      chk("mrst_in_bp", {63'b0, IN_BP}, 64'd0);
      exp_q.delete();
      exp_q2.delete();
      exp_done  = 0;
      seen_done = 0;
      exp_cnt   = '0;
      @(negedge CLK);
      @(negedge CLK);
      SYS_RST_N = 1'b1;
      pl = '{64'h0123_4567_89AB_CDEF};
      send_pkt(mk_hdr(2'b00, 32'd1), pl, 1'b0, 1'b0);
      idle(4, 1'b0, 1'b0);
      chk("prst_q_left", exp_q.size(), 64'd0);
      chk("prst_done", seen_done, exp_done);
      chk("prst_pkt_cnt", {32'b0, PKT_CNT}, {32'b0, exp_cnt});

      // counter wrap from a preloaded all-ones count
      force dut.r_pkt_cnt = 32'hFFFF_FFFF;
      idle(1, 1'b0, 1'b0);
      release dut.r_pkt_cnt;
      idle(1, 1'b0, 1'b0);
      chk("wrap_preload", {32'b0, PKT_CNT}, 64'h0000_0000_FFFF_FFFF);
      exp_cnt = 32'hFFFF_FFFF;
      base    = seen_done;
      pl = '{64'hFEED_FACE_0000_0001};
      send_pkt(mk_hdr(2'b01, 32'd1), pl, 1'b0, 1'b0);
      idle(4, 1'b0, 1'b0);
      chk("wrap_pkt_cnt", {32'b0, PKT_CNT}, {32'b0, exp_cnt});
      chk("wrap_one_pulse", seen_done - base, 64'd1);
      chk("wrap_q2_left", exp_q2.size(), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pe_stream_dist.md
# pe_stream_dist

Upstream distribution stage for the 2-input PE wrapper. It takes one 64-bit packetised word stream, typically from the host/RIFFA channel, and steers payload words onto the PE's two input ports (D/D2), or drops them, according to a header word. It buffers internally, honours the PE's almost-full backpressure and presents the same almost-full backpressure style to its own source.

## Interface
Parameters:
- DEPTH, 16: input buffer depth in words. Must be a power of 2, at least 8.
- BP_MARGIN, 4: IN_BP asserts when buffered count >= DEPTH-BP_MARGIN.

Ports:
- CLK  in  1  sole clock, rising edge.
- SYS_RST_N  in  1  asynchronous, active-low reset.
- IN  in  64  input word.
- IN_VALID  in  1  IN is valid this cycle; there is no ready.
- IN_BP  out  1  backpressure to source. Source stops within BP_MARGIN-1 cycles of assertion.
- Q  out  64  PE input 1 data.
- Q_VALID  out  1  Q valid this cycle.
- Q_BP  in  1  PE input 1 almost-full.
- Q2  out  64  PE input 2 data.
- Q2_VALID  out  1  Q2 valid this cycle.
- Q2_BP  in  1  PE input 2 almost-full.
- PKT_DONE  out  1  one-cycle pulse when a packet completes.
- PKT_CNT  out  32  completed-packet counter, wraps.
- OVF  out  1  sticky flag: an input word was lost to buffer overflow.

## Operation
- Packet = 1 header word followed by N payload words.
- Header fields:
  - [63:62] MODE: 00 = all to Q; 01 = all to Q2; 10 = interleave (payload index i even -> Q, odd -> Q2); 11 = drop.
  - [31:0] N, unsigned.
  - [61:32] ignored.
- Header words never appear on Q or Q2.
- FSM states: HDR, PAY, DROP. All state lives in registers.
  - HDR: pop the head word and latch MODE and N.
    - N=0: stay in HDR and pulse PKT_DONE.
    - MODE=11: go to DROP.
    - Otherwise: go to PAY.
    - Load remaining count REM=N and index IDX=0.
  - PAY: the target is Q (MODE 00), Q2 (MODE 01), or, for MODE 10, Q when IDX[0]=0 and Q2 otherwise.
    - Pop only when the buffer is non-empty and the target's BP is 0.
    - On pop: target data register <= word, target VALID <= 1, REM--, IDX++.
    - When REM goes 1->0: pulse PKT_DONE and go to HDR.
  - DROP: pop one word per cycle whenever the buffer is non-empty. Outputs stay idle. REM counts down the same way, then PKT_DONE and HDR.
- Q_VALID/Q2_VALID are 0 on every cycle without a pop to that port. Q/Q2 hold their last value.
- In MODE 10, a Q2 stall blocks the Q words queued behind it. Order is strict.
- PKT_CNT increments on each PKT_DONE; 0xFFFFFFFF wraps to 0.
- Input buffer write rule:
  - A write happens when IN_VALID=1 and either count<DEPTH or a pop occurs on the same edge.
  - Otherwise the word is discarded and OVF is set.
  - OVF clears only on reset.
- IN_BP is decoded from the registered count only. There is no combinational path from any input.
- Reset, at any time including mid-packet: buffer emptied, FSM to HDR, REM=IDX=0, any partial packet discarded. All outputs are 0: Q, Q2, Q_VALID, Q2_VALID, PKT_DONE, PKT_CNT, OVF, IN_BP. After release, the first accepted word is treated as a header.

## Timing
- Write at edge k; the earliest pop is at edge k+1. A payload word reaches Q or Q2 with VALID=1 in the cycle after edge k+1, giving 1-cycle latency with no backpressure.
- Header pop costs one cycle. Throughput is 1 payload word per cycle thereafter. Back-to-back packets have no extra bubble beyond the header.
- BP sampling: Q_BP/Q2_BP are sampled at the pop edge. When BP is 1, no new word is sent to that port on that edge. The PE tolerates the in-flight slack through its almost-full margin.
- IN_BP reflects the count after the previous edge. Simultaneous write and pop leaves count unchanged.
- PKT_DONE is high for the single cycle after the edge that pops the final payload word, or the header when N=0.

## Test plan
- **Mode 00 with backpressure.** Header 0x0000_0000_0000_0003 plus words A,B,C, with Q_BP held 1 for 5 cycles mid-packet. Expect: Q carries A,B,C in order; nothing is sent while Q_BP is high; Q2_VALID never rises; one PKT_DONE pulse; PKT_CNT=1.
- **Interleave.** Header MODE=10, N=4, words 1,2,3,4. Expect: Q gets 1,3 and Q2 gets 2,4. With Q2_BP=1 throughout, Q delivers 1 and then stalls; word 3 is not sent until Q2_BP drops.
- **N=0 and drop.** Header N=0, then a header with MODE=11, N=2 plus 2 words, then a MODE 01, N=1 packet with word X. Expect: no VALID on either port for the first two packets; 3 PKT_DONE pulses in total; Q2 carries X; PKT_CNT=3.
- **Overflow.** DEPTH=16, both outputs blocked, 20 consecutive IN_VALID words. Expect: IN_BP=1 once count reaches 12; 16 words stored; 4 words lost; OVF=1 and stays 1.
- **Reset mid-packet.** Header N=10, deliver 4 words, assert SYS_RST_N=0 asynchronously between edges. Expect: all outputs 0 immediately. After release, a MODE 00, N=1 packet is handled correctly, giving PKT_CNT=1.
- **Counter wrap.** With PKT_CNT forced or preloaded to 0xFFFFFFFF, complete one packet. Expect: PKT_CNT=0 and PKT_DONE pulses once.
